fetch_stage: RTL and testbench

- Fetch stage (F) plus IF/ID pipeline register of the pipelined RISC-V core.
- Consumes the Execute-stage redirect (PCSrcE, PCTargetE, ALUResultE) from the branch controller and drives the instruction-memory request.
- Owns PCF. Produces InstrD, PCD, PCPlus4D and ValidD for Decode.
- Tolerates a multi-cycle instruction memory through a ready handshake. A redirect that arrives while a fetch is outstanding is held until that fetch completes.

---
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage and IF/ID pipeline register for the pipelined RISC-V core.
// Define FETCH_PERF_CNT_EN to add the fetch/redirect/bubble performance counters.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal fetching; redirects take effect when imem_ready=1
// KILL  | redirect arrived mid-fetch; waiting to drop the outstanding word
module fetch_stage #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           PCSrcE,
    input  logic [XLEN-1:0]      PCTargetE,
    input  logic [XLEN-1:0]      ALUResultE,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushD,
    output logic [XLEN-1:0]      imem_addr,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    output logic [XLEN-1:0]      PCF,
    output logic [31:0]          InstrD,
    output logic [XLEN-1:0]      PCD,
    output logic [XLEN-1:0]      PCPlus4D,
    output logic                 ValidD,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_redirect_cnt,
    output logic [31:0]          perf_bubble_cnt,
`endif
    output logic                 KillF
);

    typedef enum logic {ST_RUN = 1'b0, ST_KILL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   pcd_q, pcd_d;
    logic [XLEN-1:0]   pcp4d_q, pcp4d_d;
    logic              valid_q, valid_d;

    logic              redirect;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_plus4;
    logic              accept;
    logic              d_load;

    assign redirect = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    assign target   = (PCSrcE == 2'b10) ? {ALUResultE[XLEN-1:1], 1'b0} : PCTargetE;
    assign pc_plus4 = pc_q + XLEN'(4);
    assign accept   = imem_ready && !StallF && (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pcp4d_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4d_q <= pcp4d_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and PC selection; redirect outranks StallF in both states.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        d_load  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect && imem_ready) begin
                    pc_d = target;
                end else if (redirect) begin
                    pend_d  = target;
                    state_d = ST_KILL;
                end else if (accept) begin
                    pc_d   = pc_plus4;
                    d_load = 1'b1;
                end
            end
            ST_KILL: begin
                if (imem_ready) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = ST_RUN;
                end else if (redirect) begin
                    pend_d = target;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // IF/ID register: FlushD > StallD > load/bubble. Bubbles keep PCD/PCPlus4D.
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4d_d = pcp4d_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!StallD) begin
            if (d_load) begin
                instr_d = imem_rdata;
                pcd_d   = pc_q;
                pcp4d_d = pc_plus4;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        KillF    = (state_q == ST_KILL);
        imem_req = !rst;
    end

    assign imem_addr = pc_q;
    assign PCF       = pc_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcp4d_q;
    assign ValidD    = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt_q, fcnt_d;
    logic [31:0] rcnt_q, rcnt_d;
    logic [31:0] bcnt_q, bcnt_d;

    always_comb begin
        fcnt_d = fcnt_q + {31'd0, accept};
        rcnt_d = rcnt_q + {31'd0, redirect};
        bcnt_d = bcnt_q + {31'd0, (!FlushD && !StallD && !d_load)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_q <= '0;
            rcnt_q <= '0;
            bcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            rcnt_q <= rcnt_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign perf_fetch_cnt    = fcnt_q;
    assign perf_redirect_cnt = rcnt_q;
    assign perf_bubble_cnt   = bcnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a zero-wait memory model
// whose ready line is driven step by step.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE, ALUResultE;
    logic        StallF, StallD, FlushD;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, KillF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_redirect_cnt, perf_bubble_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hA5C3_0000 ^ {a[15:0], a[31:16]};
    endfunction

    assign imem_rdata = mem(imem_addr);

    fetch_stage dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ALUResultE(ALUResultE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt),
        .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .KillF(KillF)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; PCSrcE = 2'b00; PCTargetE = '0; ALUResultE = '0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; imem_ready = 1'b1;
        step();
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_valid", {31'd0, ValidD}, 32'd0);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_kill", {31'd0, KillF}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        step();
        chk("seq_req", {31'd0, imem_req}, 32'd1);
        chk("seq_pcf4", PCF, 32'h4);
        chk("seq_instr0", InstrD, mem(32'h0));
        chk("seq_pcd0", PCD, 32'h0);
        chk("seq_pcp4_0", PCPlus4D, 32'h4);
        chk("seq_valid0", {31'd0, ValidD}, 32'd1);
        step();
        chk("seq_pcf8", PCF, 32'h8);
        chk("seq_instr4", InstrD, mem(32'h4));

        // Branch redirect with ready
        PCSrcE = 2'b01; PCTargetE = 32'h100;
        step();
        chk("br_pcf", PCF, 32'h100);
        chk("br_instr_nop", InstrD, NOP);
        chk("br_valid", {31'd0, ValidD}, 32'd0);
        PCSrcE = 2'b00;
        step();
        chk("br_pcf2", PCF, 32'h104);
        chk("br_instr", InstrD, mem(32'h100));
        chk("br_pcd", PCD, 32'h100);
        chk("br_valid2", {31'd0, ValidD}, 32'd1);

        // JALR clears bit 0
        PCSrcE = 2'b10; ALUResultE = 32'h203;
        step();
        chk("jalr_pcf", PCF, 32'h202);
        PCSrcE = 2'b00;
        step();
        chk("jalr_pcf2", PCF, 32'h206);
        chk("jalr_instr", InstrD, mem(32'h202));

        // Reserved code acts as sequential
        PCSrcE = 2'b11; PCTargetE = 32'h500;
        step();
        chk("rsv_pcf", PCF, 32'h20A);
        chk("rsv_instr", InstrD, mem(32'h206));
        PCSrcE = 2'b00;

        // Redirect during an outstanding fetch
        imem_ready = 1'b0; PCSrcE = 2'b01; PCTargetE = 32'h40;
        step();
        chk("kill_k1", {31'd0, KillF}, 32'd1);
        chk("kill_pcf1", PCF, 32'h20A);
        chk("kill_v1", {31'd0, ValidD}, 32'd0);
        PCSrcE = 2'b00;
        step();
        chk("kill_k2", {31'd0, KillF}, 32'd1);
        chk("kill_pcf2", PCF, 32'h20A);
        step();
        chk("kill_pcf3", PCF, 32'h20A);
        imem_ready = 1'b1;
        step();
        chk("kill_done_pcf", PCF, 32'h40);
        chk("kill_done_k", {31'd0, KillF}, 32'd0);
        chk("kill_done_v", {31'd0, ValidD}, 32'd0);
        chk("kill_done_i", InstrD, NOP);
        step();
        chk("kill_next_pcf", PCF, 32'h44);
        chk("kill_next_i", InstrD, mem(32'h40));

        // Newest pending redirect wins
        imem_ready = 1'b0; PCSrcE = 2'b01; PCTargetE = 32'h40;
        step();
        PCTargetE = 32'h80;
        step();
        PCSrcE = 2'b00; imem_ready = 1'b1;
        step();
        chk("newest_pcf", PCF, 32'h80);
        chk("newest_k", {31'd0, KillF}, 32'd0);
        step();
        chk("newest_pcf2", PCF, 32'h84);
        chk("newest_i", InstrD, mem(32'h80));

        // New redirect arriving with ready in KILL
        imem_ready = 1'b0; PCSrcE = 2'b01; PCTargetE = 32'h300;
        step();
        imem_ready = 1'b1; PCSrcE = 2'b10; ALUResultE = 32'h401;
        step();
        chk("kredir_pcf", PCF, 32'h400);
        chk("kredir_k", {31'd0, KillF}, 32'd0);
        PCSrcE = 2'b00;
        step();
        chk("kredir_pcf2", PCF, 32'h404);
        chk("kredir_i", InstrD, mem(32'h400));

        // FlushD beats StallD
        StallD = 1'b1; FlushD = 1'b1;
        step();
        chk("flush_i", InstrD, NOP);
        chk("flush_v", {31'd0, ValidD}, 32'd0);
        chk("flush_pcf", PCF, 32'h408);
        StallD = 1'b0; FlushD = 1'b0;
        step();
        chk("flush_after_i", InstrD, mem(32'h408));

        // StallD holds D
        StallD = 1'b1;
        step();
        chk("stalld_i", InstrD, mem(32'h408));
        chk("stalld_pcd", PCD, 32'h408);
        chk("stalld_v", {31'd0, ValidD}, 32'd1);
        StallD = 1'b0;
        step();
        chk("stalld_rel_i", InstrD, mem(32'h410));
        chk("stalld_rel_pcf", PCF, 32'h414);

        // StallF holds PC and bubbles D
        StallF = 1'b1;
        step();
        chk("stallf_pcf", PCF, 32'h414);
        chk("stallf_v", {31'd0, ValidD}, 32'd0);
        chk("stallf_i", InstrD, NOP);

        // Redirect beats StallF, then wrap at top of address space
        PCSrcE = 2'b01; PCTargetE = 32'hFFFF_FFF8;
        step();
        chk("rbs_pcf", PCF, 32'hFFFF_FFF8);
        StallF = 1'b0; PCSrcE = 2'b00;
        step();
        chk("wrap_pcf1", PCF, 32'hFFFF_FFFC);
        chk("wrap_i1", InstrD, mem(32'hFFFF_FFF8));
        step();
        chk("wrap_pcf0", PCF, 32'h0);
        chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
        chk("wrap_pcp4", PCPlus4D, 32'h0);

        // Reset in KILL drops the pending target
        imem_ready = 1'b0; PCSrcE = 2'b01; PCTargetE = 32'h600;
        step();
        chk("rk_kill", {31'd0, KillF}, 32'd1);
        PCSrcE = 2'b00; rst = 1'b1;
        step();
        chk("rk_pcf", PCF, 32'h0);
        chk("rk_k", {31'd0, KillF}, 32'd0);
        chk("rk_v", {31'd0, ValidD}, 32'd0);
        chk("rk_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0; imem_ready = 1'b1;
        step();
        chk("rk_after_pcf", PCF, 32'h4);
        chk("rk_after_i", InstrD, mem(32'h0));
        chk("rk_after_v", {31'd0, ValidD}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
